// File: rtl/pattern_serializer_m.sv
// Object-row pixel serializer: holds one active and one pending 8-pixel pattern row,
// waits for the raster to reach the row's X, then shifts pixels out MSB pair first.
module pattern_serializer_m #(
  parameter int XW = 8,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic          pixel_en,
  input  logic [XW-1:0] x,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [15:0]   load_pattern,
  input  logic [XW-1:0] load_x,
  input  logic [CW-1:0] load_color,
  output logic [1:0]    pix_out,
  output logic [CW-1:0] pix_color,
  output logic          pix_opaque,
  output logic          busy
);

  // Handshake: a row transfers on any rising edge where load_valid && load_ready.
  // load_ready depends only on pre-edge pending occupancy, line_start and rst;
  // upstream holds its data stable while load_valid && !load_ready.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   act_pat_q, act_pat_d;
  logic [XW-1:0] act_x_q, act_x_d;
  logic [CW-1:0] act_color_q, act_color_d;
  logic [2:0]    count_q, count_d;

  logic          pend_full_q, pend_full_d;
  logic [15:0]   pend_pat_q, pend_pat_d;
  logic [XW-1:0] pend_x_q, pend_x_d;
  logic [CW-1:0] pend_color_q, pend_color_d;

  logic [1:0]    pix_out_q, pix_out_d;
  logic [CW-1:0] pix_color_q, pix_color_d;
  logic          pix_opaque_q, pix_opaque_d;

  logic          load_fire;
  logic          emit;
  logic          take_pend;
  logic [1:0]    emit_pix;

  assign load_ready = !pend_full_q && !line_start && !rst;
  assign load_fire  = load_valid && load_ready;
  assign busy       = (state_q != ST_EMPTY) || pend_full_q;
  assign pix_out    = pix_out_q;
  assign pix_color  = pix_color_q;
  assign pix_opaque = pix_opaque_q;

  // The active pattern shifts left as it emits, so the next pixel is always in [15:14].
  assign emit_pix = act_pat_q[15:14];

  always_comb begin
    state_d      = state_q;
    act_pat_d    = act_pat_q;
    act_x_d      = act_x_q;
    act_color_d  = act_color_q;
    count_d      = count_q;
    pend_full_d  = pend_full_q;
    pend_pat_d   = pend_pat_q;
    pend_x_d     = pend_x_q;
    pend_color_d = pend_color_q;
    pix_out_d    = pix_out_q;
    pix_color_d  = pix_color_q;
    pix_opaque_d = pix_opaque_q;
    emit         = 1'b0;
    take_pend    = 1'b0;

    if (line_start) begin
      state_d      = ST_EMPTY;
      pend_full_d  = 1'b0;
      count_d      = 3'd0;
      pix_out_d    = 2'd0;
      pix_color_d  = '0;
      pix_opaque_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pend_full_q) take_pend = 1'b1;
        end
        ST_ARMED: begin
          if (pixel_en && (x == act_x_q)) begin
            emit      = 1'b1;
            act_pat_d = {act_pat_q[13:0], 2'b00};
            count_d   = 3'd1;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (pixel_en) begin
            emit      = 1'b1;
            act_pat_d = {act_pat_q[13:0], 2'b00};
            count_d   = count_q + 3'd1;
            // Last pixel: hand straight over to the pending row so adjacent objects abut.
            if (count_q == 3'd7) begin
              if (pend_full_q) take_pend = 1'b1;
              else             state_d   = ST_EMPTY;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase

      if (take_pend) begin
        state_d     = ST_ARMED;
        act_pat_d   = pend_pat_q;
        act_x_d     = pend_x_q;
        act_color_d = pend_color_q;
        count_d     = 3'd0;
        pend_full_d = 1'b0;
      end

      if (load_fire) begin
        pend_full_d  = 1'b1;
        pend_pat_d   = load_pattern;
        pend_x_d     = load_x;
        pend_color_d = load_color;
      end

      if (pixel_en) begin
        pix_out_d    = emit ? emit_pix : 2'd0;
        pix_color_d  = emit ? act_color_q : '0;
        pix_opaque_d = emit && (emit_pix != 2'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      act_pat_q    <= '0;
      act_x_q      <= '0;
      act_color_q  <= '0;
      count_q      <= 3'd0;
      pend_full_q  <= 1'b0;
      pend_pat_q   <= '0;
      pend_x_q     <= '0;
      pend_color_q <= '0;
      pix_out_q    <= 2'd0;
      pix_color_q  <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_pat_q    <= act_pat_d;
      act_x_q      <= act_x_d;
      act_color_q  <= act_color_d;
      count_q      <= count_d;
      pend_full_q  <= pend_full_d;
      pend_pat_q   <= pend_pat_d;
      pend_x_q     <= pend_x_d;
      pend_color_q <= pend_color_d;
      pix_out_q    <= pix_out_d;
      pix_color_q  <= pix_color_d;
      pix_opaque_q <= pix_opaque_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer_m.sv
// Directed bench for pattern_serializer_m: the driver queues the expected
// {pix_out, pix_color, pix_opaque} for every cycle; a monitor pops and compares.
module tb_pattern_serializer_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic        pixel_en;
  logic [7:0]  x;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_pattern;
  logic [7:0]  load_x;
  logic [1:0]  load_color;
  logic [1:0]  pix_out;
  logic [1:0]  pix_color;
  logic        pix_opaque;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  logic [4:0] exp_q[$];
  logic [4:0] exp_cur = 5'd0;

  // Hand-decoded pixel sequences, pixel 0 first.
  logic [1:0] t_e41b [0:7] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] t_1b1b [0:7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] t_5a5a [0:7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2};

  pattern_serializer_m #(.XW(8), .CW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_start   (line_start),
    .pixel_en     (pixel_en),
    .x            (x),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_x       (load_x),
    .load_color   (load_color),
    .pix_out      (pix_out),
    .pix_color    (pix_color),
    .pix_opaque   (pix_opaque),
    .busy         (busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] px(input logic [1:0] p, input logic [1:0] c);
    return {p, c, (p != 2'd0)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, queue the output expected after the edge.
  // e is taken only when the edge updates outputs; otherwise outputs hold.
  task automatic cyc(input bit pe, input logic [7:0] xv, input bit ls, input logic [4:0] e);
    pixel_en   = pe;
    x          = xv;
    line_start = ls;
    if (pe || ls || rst) exp_cur = e;
    exp_q.push_back(exp_cur);
    @(posedge clk);
    #2;
  endtask

  task automatic load_row(input logic [15:0] pat, input logic [7:0] lx,
                          input logic [1:0] lc, input logic [7:0] xv);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    load_pattern = pat;
    load_x       = lx;
    load_color   = lc;
    load_valid   = 1'b1;
    pixel_en     = 1'b0;
    line_start   = 1'b0;
    while (!acc && n < 20) begin
      #1;
      acc = load_ready;
      cyc(1'b0, xv, 1'b0, 5'd0);
      n++;
    end
    load_valid = 1'b0;
    check("load_accepted", {7'd0, acc}, 8'd1);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({pix_out, pix_color, pix_opaque} !== e) begin
          n_fails++;
          $display("FAIL pix_stream @%0t x=%0d: got out=%0d col=%0d op=%0b, required out=%0d col=%0d op=%0b",
                   $time, x, pix_out, pix_color, pix_opaque, e[4:3], e[2:1], e[0]);
        end
      end
    end
  end

  // Driver
  initial begin
    logic [4:0] e;
    rst = 1'b1; line_start = 1'b0; pixel_en = 1'b0; x = 8'd0;
    load_valid = 1'b0; load_pattern = 16'd0; load_x = 8'd0; load_color = 2'd0;

    // 1. Reset then idle
    cyc(1'b0, 8'd0, 1'b0, 5'd0);
    #1 check("load_ready_in_reset", {7'd0, load_ready}, 8'd0);
    cyc(1'b0, 8'd0, 1'b0, 5'd0);
    rst = 1'b0;
    #1;
    check("busy_after_reset", {7'd0, busy}, 8'd0);
    check("load_ready_after_reset", {7'd0, load_ready}, 8'd1);
    for (int i = 0; i < 4; i++) cyc(i[0], 8'(i), 1'b0, 5'd0);

    // 2. Single row at x=10, colour 2
    load_row(16'hE41B, 8'd10, 2'd2, 8'd0);
    #1 check("busy_loaded", {7'd0, busy}, 8'd1);
    for (int xi = 0; xi < 26; xi++) begin
      e = (xi >= 10 && xi <= 17) ? px(t_e41b[xi-10], 2'd2) : 5'd0;
      cyc(1'b1, 8'(xi), 1'b0, e);
    end
    #1 check("busy_after_row", {7'd0, busy}, 8'd0);

    // 3. Queued adjacent rows A@20 and B@28 must abut
    load_row(16'h1B1B, 8'd20, 2'd3, 8'd0);
    load_row(16'h5A5A, 8'd28, 2'd1, 8'd0);
    #1 check("load_ready_pending_full", {7'd0, load_ready}, 8'd0);
    for (int xi = 0; xi < 41; xi++) begin
      if (xi >= 20 && xi <= 27)      e = px(t_1b1b[xi-20], 2'd3);
      else if (xi >= 28 && xi <= 35) e = px(t_5a5a[xi-28], 2'd1);
      else                           e = 5'd0;
      if (xi == 25) check("load_ready_while_b_pending", {7'd0, load_ready}, 8'd0);
      cyc(1'b1, 8'(xi), 1'b0, e);
    end
    #1;
    check("busy_after_pair", {7'd0, busy}, 8'd0);
    check("load_ready_after_pair", {7'd0, load_ready}, 8'd1);

    // 4. Missed X: row at 5 loaded once raster is at 40
    load_row(16'hFFFF, 8'd5, 2'd3, 8'd40);
    for (int xi = 40; xi <= 60; xi++) cyc(1'b1, 8'(xi), 1'b0, 5'd0);
    #1 check("busy_missed_x", {7'd0, busy}, 8'd1);
    cyc(1'b0, 8'd60, 1'b1, 5'd0);
    #1 check("busy_after_line_start", {7'd0, busy}, 8'd0);

    // 5. pixel_en every third cycle
    load_row(16'hE41B, 8'd100, 2'd1, 8'd95);
    for (int xi = 95; xi <= 110; xi++) begin
      e = (xi >= 100 && xi <= 107) ? px(t_e41b[xi-100], 2'd1) : 5'd0;
      cyc(1'b1, 8'(xi), 1'b0, e);
      cyc(1'b0, 8'(xi), 1'b0, 5'd0);
      cyc(1'b0, 8'(xi), 1'b0, 5'd0);
    end
    #1 check("busy_after_gapped", {7'd0, busy}, 8'd0);

    // 6. line_start after pixel 3, with a new row already offered
    load_row(16'hE41B, 8'd150, 2'd2, 8'd148);
    for (int xi = 148; xi <= 153; xi++) begin
      e = (xi >= 150) ? px(t_e41b[xi-150], 2'd2) : 5'd0;
      cyc(1'b1, 8'(xi), 1'b0, e);
    end
    load_pattern = 16'hFFFF; load_x = 8'd200; load_color = 2'd3; load_valid = 1'b1;
    line_start = 1'b1;
    #1 check("load_ready_during_line_start", {7'd0, load_ready}, 8'd0);
    cyc(1'b1, 8'd154, 1'b1, 5'd0);
    #1 check("busy_after_abort", {7'd0, busy}, 8'd0);
    line_start = 1'b0;
    #1 check("load_ready_after_abort", {7'd0, load_ready}, 8'd1);
    cyc(1'b0, 8'd154, 1'b0, 5'd0);
    load_valid = 1'b0;
    #1 check("busy_load_after_abort", {7'd0, busy}, 8'd1);
    cyc(1'b0, 8'd154, 1'b1, 5'd0);
    #1 check("busy_final_flush", {7'd0, busy}, 8'd0);

    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
